mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage between EX/MEM and WB. It drives the data-memory req/gnt/rvalid bus.
//  It aligns store data and byte enables, and aligns and sign- or zero-extends load data.
//  It raises stall_m to the hazard unit while an access is outstanding.
//  It holds the MEM/WB pipeline register whose outputs feed WB (regwrite_w, result_src_w, ...).
// PARAMETERS
//  TIMEOUT_CYCLES  256  max cycles in WAIT_R before the load is aborted with bus_err_w
// PORTS
//  clk            in   1   single clock; all flops on posedge
//  reset_n        in   1   asynchronous, active-low reset
//  valid_m        in   1   MEM slot holds a real instruction
//  regwrite_m     in   1   writes rd
//  result_src_m   in   2   00 alu, 01 load, 10 pc+4; 01 marks a load
//  mem_write_m    in   1   store
//  funct3_m       in   3   load/store size and sign
//  alu_result_m   in   32  effective address or ALU result
//  write_data_m   in   32  store data (rs2)
//  rd_m           in   5   destination register
//  pc_plus_4_m    in   32  link value
//  dmem_req       out  1   request valid (combinational)
//  dmem_we        out  1   1 = write
//  dmem_addr      out  32  {alu_result_m[31:2],2'b00}
//  dmem_be        out  4   byte enables
//  dmem_wdata     out  32  lane-shifted store data
//  dmem_gnt       in   1   request accepted this cycle
//  dmem_rvalid    in   1   load data valid (>=1 cycle after gnt)
//  dmem_rdata     in   32  load word
//  stall_m        out  1   freeze IF..EX/MEM this cycle
//  regwrite_w, result_src_w[2], alu_result_w[32], readdata_w[32], rd_w[5], pc_plus_4_w[32]  out  MEM/WB register
//  misalign_err_w out  1   registered; 1 for one WB slot on misaligned or illegal funct3
//  bus_err_w      out  1   registered; 1 for one WB slot on load timeout
// BEHAVIOUR
//  Reset: FSM=IDLE, counter=0, all MEM/WB outputs and error flags are 0.
//  access = valid_m & (load | mem_write_m) & ~bad.
//  bad = funct3 not in {000,001,010,100,101} for loads, or not in {000,001,010} for stores.
//  bad is also set for a half access with addr[0]=1 or a word access with addr[1:0]!=0.
//  FSM IDLE:
//   dmem_req=access.
//   gnt & store -> access complete, stay in IDLE.
//   gnt & load -> WAIT_R.
//   IDLE ignores rvalid.
//  FSM WAIT_R:
//   dmem_req=0; counter increments.
//   rvalid -> complete, go to IDLE.
//   counter==TIMEOUT_CYCLES-1 -> complete with readdata 0 and bus_err, go to IDLE.
//  stall_m = (IDLE & access & ~(gnt & store)) | (WAIT_R & ~rvalid & ~timeout).
//  MEM/WB update each edge:
//   if stall_m, load a bubble: regwrite_w=0, rd_w=0, result_src_w=00, errors=0.
//   otherwise capture the *_m fields.
//   regwrite_w = regwrite_m & valid_m & ~bad & ~timeout.
//  Stores: lane = addr[1:0].
//   sb: be=1<<lane, wdata=byte replicated x4.
//   sh: be=0011 or 1100, wdata=half replicated x2.
//   sw: be=1111.
//  Loads: select byte/half by addr[1:0], then sign-extend (lb, lh) or zero-extend (lbu, lhu).
//  A load's readdata_w is captured on the same edge rvalid is sampled, so WB sees data one cycle after rvalid.
//  Single-cycle store: stall_m=0 when gnt arrives in the request cycle.
//  Non-memory instructions pass with zero added latency.
//  Reset mid-access returns the FSM to IDLE; a late rvalid is dropped and nothing is written.
// STRUCTURE
//  Package riscv_pkg holds: funct3 localparams (F3_B/H/W/BU/HU), RES_ALU/RES_LOAD/RES_PC4,
//  and the FSM state enum (IDLE, WAIT_R).
//  Sub-module lsu_align (combinational): addr[1:0] + funct3 -> be, wdata, extended rdata.
//  FSM, counter and MEM/WB register live in the top.
// TESTING
//  1 sw 0x11223344 @0x100, gnt same cycle -> be=1111, wdata=0x11223344, stall_m=0, regwrite_w=0 next.
//  2 lb @0x103, rdata=0x80FF1234 -> readdata_w=0xFFFFFF80; lbu -> 0x00000080; lhu @0x102 -> 0x000080FF.
//  3 sh 0x0000ABCD @0x102 -> be=1100, wdata=0xABCDABCD; sb 0x5A @0x101 -> be=0010.
//  4 lw, gnt after 2 cycles, rvalid 3 cycles after gnt -> stall_m high 5 cycles, regwrite_w=0 bubbles, then data.
//  5 lw @0x101 -> no dmem_req, stall_m=0, misalign_err_w=1, regwrite_w=0 for that slot.
//  6 reset_n low in WAIT_R -> outputs 0, late rvalid ignored; rvalid never -> bus_err_w after 256 cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the MEM stage: funct3 size/sign codes, WB result
// source select codes and the MEM access state machine encoding.
// No ports (package).
package riscv_pkg;

    // Load/store size and sign (instruction funct3 field)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // WB result source select; RES_LOAD also marks an instruction as a load
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        WAIT_R = 1'b1
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment for the data-memory port.
// Ports:
//   lane       in  2   address bits [1:0]
//   funct3     in  3   access size and sign
//   store_data in  32  unshifted store data (rs2)
//   load_word  in  32  raw word returned by memory
//   be         out 4   byte enables for the access
//   wdata      out 32  store data replicated onto every lane it can occupy
//   rdata_ext  out 32  selected load byte/half, sign- or zero-extended
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be        = 4'b0000;
        wdata     = store_data;
        rdata_ext = load_word;
        byte_sel  = load_word[{lane, 3'b000} +: 8];
        // Half accesses are only legal on lane 0 or 2, so lane[1] picks the half.
        half_sel  = lane[1] ? load_word[31:16] : load_word[15:0];
        case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << lane;
                wdata     = {4{store_data[7:0]}};
                rdata_ext = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'b0, byte_sel};
            end
            F3_H, F3_HU: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                rdata_ext = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                             : {16'b0, half_sel};
            end
            F3_W: begin
                be = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory bus, aligns store/load data,
// stalls the front of the pipe while an access is outstanding and holds the
// MEM/WB pipeline register.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   valid_m .. pc_plus_4_m           EX/MEM register fields
//   dmem_req/we/addr/be/wdata        request side of the memory bus
//   dmem_gnt/rvalid/rdata            response side of the memory bus
//   stall_m                          freeze IF..EX/MEM this cycle
//   regwrite_w .. pc_plus_4_w        MEM/WB register
//   misalign_err_w, bus_err_w        one-slot error flags in WB
//   fsm_state                        current access state (debug)
//
// Bus handshake: a request is presented while dmem_req=1 and is accepted in
// the cycle dmem_gnt=1 (req is held, unchanged, until then). Load data returns
// on a later cycle with dmem_rvalid=1; rvalid is only meaningful in WAIT_R.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_m,
    input  logic        regwrite_m,
    input  logic [1:0]  result_src_m,
    input  logic        mem_write_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] write_data_m,
    input  logic [4:0]  rd_m,
    input  logic [31:0] pc_plus_4_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_m,
    output logic        regwrite_w,
    output logic [1:0]  result_src_w,
    output logic [31:0] alu_result_w,
    output logic [31:0] readdata_w,
    output logic [4:0]  rd_w,
    output logic [31:0] pc_plus_4_w,
    output logic        misalign_err_w,
    output logic        bus_err_w,
    output state_t      fsm_state
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic          is_load, is_store, f3_ok, misaligned, bad, access;
    logic          in_wait, timeout;
    logic [31:0]   rdata_ext;

    // A store wins if both store and load markers are set.
    assign is_store = mem_write_m;
    assign is_load  = (result_src_m == RES_LOAD) && !mem_write_m;

    always_comb begin
        f3_ok      = 1'b0;
        misaligned = 1'b0;
        case (funct3_m)
            F3_B:  f3_ok = 1'b1;
            F3_H:  begin f3_ok = 1'b1;    misaligned = alu_result_m[0];    end
            F3_W:  begin f3_ok = 1'b1;    misaligned = |alu_result_m[1:0]; end
            F3_BU: f3_ok = is_load;
            F3_HU: begin f3_ok = is_load; misaligned = alu_result_m[0];    end
            default: ;
        endcase
        bad = (is_load || is_store) && (!f3_ok || misaligned);
    end

    assign access  = valid_m && (is_load || is_store) && !bad;
    assign in_wait = (state == WAIT_R);
    // rvalid on the last allowed cycle still counts as a normal completion.
    assign timeout = in_wait && !dmem_rvalid
                     && (count == CW'(TIMEOUT_CYCLES - 1));

    assign stall_m = (!in_wait && access && !(dmem_gnt && is_store))
                   || (in_wait && !dmem_rvalid && !timeout);

    assign dmem_req  = !in_wait && access;
    assign dmem_we   = dmem_req && is_store;
    assign dmem_addr = {alu_result_m[31:2], 2'b00};
    assign fsm_state = state;

    lsu_align u_align (
        .lane       (alu_result_m[1:0]),
        .funct3     (funct3_m),
        .store_data (write_data_m),
        .load_word  (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .rdata_ext  (rdata_ext)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (access && dmem_gnt && is_load) state_next = WAIT_R;
            WAIT_R:  if (dmem_rvalid || timeout)        state_next = IDLE;
            default: state_next = IDLE;
        endcase
        count_next = (in_wait && state_next == WAIT_R) ? count + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= '0;
            regwrite_w     <= 1'b0;
            result_src_w   <= RES_ALU;
            alu_result_w   <= '0;
            readdata_w     <= '0;
            rd_w           <= '0;
            pc_plus_4_w    <= '0;
            misalign_err_w <= 1'b0;
            bus_err_w      <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (stall_m) begin
                // Bubble: WB must see a harmless no-op while MEM is held.
                regwrite_w     <= 1'b0;
                result_src_w   <= RES_ALU;
                alu_result_w   <= '0;
                readdata_w     <= '0;
                rd_w           <= '0;
                pc_plus_4_w    <= '0;
                misalign_err_w <= 1'b0;
                bus_err_w      <= 1'b0;
            end else begin
                regwrite_w     <= regwrite_m && valid_m && !bad && !timeout;
                result_src_w   <= result_src_m;
                alu_result_w   <= alu_result_m;
                readdata_w     <= (in_wait && dmem_rvalid) ? rdata_ext : '0;
                rd_w           <= rd_m;
                pc_plus_4_w    <= pc_plus_4_m;
                misalign_err_w <= valid_m && bad;
                bus_err_w      <= timeout;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized
// instruction/bus timing, checked against a transaction-level model.
module tb_mem_stage;
    import riscv_pkg::*;

    localparam int TO = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_m, regwrite_m, mem_write_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_result_m, write_data_m, pc_plus_4_m;
    logic [4:0]  rd_m;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, stall_m;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        regwrite_w, misalign_err_w, bus_err_w;
    logic [1:0]  result_src_w;
    logic [31:0] alu_result_w, readdata_w, pc_plus_4_w;
    logic [4:0]  rd_w;
    state_t      fsm_state;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .valid_m(valid_m), .regwrite_m(regwrite_m),
        .result_src_m(result_src_m), .mem_write_m(mem_write_m), .funct3_m(funct3_m),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m), .rd_m(rd_m),
        .pc_plus_4_m(pc_plus_4_m), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall_m(stall_m), .regwrite_w(regwrite_w), .result_src_w(result_src_w),
        .alu_result_w(alu_result_w), .readdata_w(readdata_w), .rd_w(rd_w),
        .pc_plus_4_w(pc_plus_4_w), .misalign_err_w(misalign_err_w),
        .bus_err_w(bus_err_w), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- types / counters ----------------
    typedef struct {
        logic        valid, regwrite, mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
    } ins_t;

    typedef struct {
        logic        req, we, stall, in_wait, bubble, chk_rd;
        logic [31:0] addr, wdata, alu, rdata, pc4;
        logic [3:0]  be;
        logic        regwrite, mis, berr;
        logic [1:0]  rs;
        logic [4:0]  rd;
    } cyc_t;

    cyc_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   stall_cnt = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_is_load(input ins_t i);
        return (i.rs == 2'b01) && !i.mw;
    endfunction

    function automatic bit m_bad(input ins_t i);
        bit ld, st;
        int sz;
        ld = m_is_load(i);
        st = i.mw;
        if (!ld && !st) return 1'b0;
        if (st && !(i.f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        if (ld && !(i.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        sz = 1 << i.f3[1:0];
        return (int'(i.alu[1:0]) % sz) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(lane))) & 32'hFF;
        h = (w >> (8 * int'(lane))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'd0:    return 4'(1 << int'(lane));
            2'd1:    return (lane == 2'd2) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'd0:    return {24'b0, d[7:0]} * 32'h01010101;
            2'd1:    return {16'b0, d[15:0]} * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic cyc_t fill_wb(input cyc_t c0, input ins_t i, input bit to,
                                     input logic [31:0] rdv, input bit chk_rd);
        cyc_t c;
        bit bd;
        c = c0;
        bd = m_bad(i);
        c.stall    = 1'b0;
        c.bubble   = 1'b0;
        c.regwrite = i.regwrite && i.valid && !bd && !to;
        c.rs       = i.rs;
        c.alu      = i.alu;
        c.pc4      = i.pc4;
        c.rd       = i.rd;
        c.mis      = i.valid && bd;
        c.berr     = to;
        c.rdata    = rdv;
        c.chk_rd   = chk_rd;
        return c;
    endfunction

    function automatic ins_t mk(input logic v, input logic rw, input logic [1:0] rs,
                                input logic mw, input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [4:0] rd);
        ins_t i;
        i.valid = v; i.regwrite = rw; i.rs = rs; i.mw = mw; i.f3 = f3;
        i.alu = alu; i.wd = wd; i.rd = rd; i.pc4 = alu ^ 32'h5555_0004;
        return i;
    endfunction

    // ---------------- driver ----------------
    function automatic logic stray();
        return 1'($urandom_range(0, 3) == 0);
    endfunction

    task automatic set_m(input ins_t i);
        valid_m = i.valid; regwrite_m = i.regwrite; result_src_m = i.rs;
        mem_write_m = i.mw; funct3_m = i.f3; alu_result_m = i.alu;
        write_data_m = i.wd; rd_m = i.rd; pc_plus_4_m = i.pc4;
    endtask

    task automatic one_cycle(input cyc_t c, input logic gnt, input logic rv,
                             input logic [31:0] rw);
        dmem_gnt = gnt; dmem_rvalid = rv; dmem_rdata = rw;
        exp_q.push_back(c);
        @(posedge clk); #1;
    endtask

    // g = cycles of waiting before gnt; r = cycles from gnt to rvalid (<0: never)
    task automatic do_instr(input ins_t i, input int g, input int r, input logic [31:0] rword);
        cyc_t c;
        bit ld, st, acc;
        ld  = m_is_load(i);
        st  = i.mw;
        acc = i.valid && (ld || st) && !m_bad(i);
        set_m(i);
        c = '{default: '0};
        c.addr  = {i.alu[31:2], 2'b00};
        c.we    = st;
        c.be    = m_be(i.f3, i.alu[1:0]);
        c.wdata = m_wdata(i.f3, i.wd);
        if (!acc) begin
            c = fill_wb(c, i, 1'b0, 32'h0, 1'b0);
            one_cycle(c, 1'b0, stray(), $urandom);
        end else begin
            c.req = 1'b1; c.stall = 1'b1; c.bubble = 1'b1;
            for (int n = 0; n < g; n++) one_cycle(c, 1'b0, stray(), $urandom);
            if (st) begin
                c = fill_wb(c, i, 1'b0, 32'h0, 1'b0);
                one_cycle(c, 1'b1, stray(), $urandom);
            end else begin
                one_cycle(c, 1'b1, 1'b0, $urandom);
                c.req = 1'b0; c.in_wait = 1'b1;
                if (r < 0) begin
                    for (int n = 0; n < TO - 1; n++) one_cycle(c, 1'b0, 1'b0, $urandom);
                    c = fill_wb(c, i, 1'b1, 32'h0, 1'b1);
                    one_cycle(c, 1'b0, 1'b0, $urandom);
                end else begin
                    for (int n = 0; n < r - 1; n++) one_cycle(c, 1'b0, 1'b0, $urandom);
                    c = fill_wb(c, i, 1'b0, m_load(i.f3, i.alu[1:0], rword), 1'b1);
                    one_cycle(c, 1'b0, 1'b1, rword);
                end
            end
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    // ---------------- scoreboard / compare ----------------
    cyc_t prev, cur;
    bit   have_prev = 1'b0;

    always @(negedge clk) begin
        if (!chk_en) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                chk("wb_regwrite", 32'(regwrite_w), 32'(prev.regwrite));
                chk("wb_rd", 32'(rd_w), 32'(prev.rd));
                chk("wb_result_src", 32'(result_src_w), 32'(prev.rs));
                chk("wb_misalign_err", 32'(misalign_err_w), 32'(prev.mis));
                chk("wb_bus_err", 32'(bus_err_w), 32'(prev.berr));
                if (!prev.bubble) begin
                    chk("wb_alu_result", alu_result_w, prev.alu);
                    chk("wb_pc_plus_4", pc_plus_4_w, prev.pc4);
                    if (prev.chk_rd) chk("wb_readdata", readdata_w, prev.rdata);
                end
            end
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                if (stall_m === 1'b1) stall_cnt++;
                chk("stall_m", 32'(stall_m), 32'(cur.stall));
                chk("dmem_req", 32'(dmem_req), 32'(cur.req));
                chk("fsm_state", 32'(fsm_state), 32'(cur.in_wait));
                if (cur.req) begin
                    chk("dmem_addr", dmem_addr, cur.addr);
                    chk("dmem_we", 32'(dmem_we), 32'(cur.we));
                    if (cur.we) begin
                        chk("dmem_be", 32'(dmem_be), 32'(cur.be));
                        chk("dmem_wdata", dmem_wdata, cur.wdata);
                    end
                end
                prev = cur;
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    ins_t ri;
    int   kind;
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        reset_n = 1'b0;
        set_m(mk(0, 0, RES_ALU, 0, 3'd0, 32'h0, 32'h0, 5'd0));
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regwrite_w", 32'(regwrite_w), 32'h0);
        chk("rst_rd_w", 32'(rd_w), 32'h0);
        chk("rst_readdata_w", readdata_w, 32'h0);
        chk("rst_alu_result_w", alu_result_w, 32'h0);
        chk("rst_bus_err_w", 32'(bus_err_w), 32'h0);
        chk("rst_misalign_err_w", 32'(misalign_err_w), 32'h0);
        chk("rst_state", 32'(fsm_state), 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // model pinning against hand-computed values
        chk("model_lb", m_load(3'b000, 2'd3, 32'h80FF1234), 32'hFFFFFF80);
        chk("model_lbu", m_load(3'b100, 2'd3, 32'h80FF1234), 32'h00000080);
        chk("model_lhu", m_load(3'b101, 2'd2, 32'h80FF1234), 32'h000080FF);
        chk("model_sh_be", 32'(m_be(3'b001, 2'd2)), 32'hC);
        chk("model_sh_wdata", m_wdata(3'b001, 32'h0000ABCD), 32'hABCDABCD);
        chk("model_sb_be", 32'(m_be(3'b000, 2'd1)), 32'h2);
        chk("model_lw_misalign", 32'(m_bad(mk(1, 1, RES_LOAD, 0, F3_W, 32'h101, 0, 5'd1))), 32'h1);

        chk_en = 1'b1;
        // directed cases
        stall_cnt = 0;
        do_instr(mk(1, 0, RES_ALU, 1, F3_W, 32'h100, 32'h11223344, 5'd0), 0, 0, 0);
        chk("sw_single_cycle_stalls", 32'(stall_cnt), 32'd0);
        do_instr(mk(1, 1, RES_LOAD, 0, F3_B, 32'h103, 0, 5'd3), 0, 1, 32'h80FF1234);
        do_instr(mk(1, 1, RES_LOAD, 0, F3_BU, 32'h103, 0, 5'd4), 1, 2, 32'h80FF1234);
        do_instr(mk(1, 1, RES_LOAD, 0, F3_HU, 32'h102, 0, 5'd5), 0, 1, 32'h80FF1234);
        do_instr(mk(1, 0, RES_ALU, 1, F3_H, 32'h102, 32'h0000ABCD, 5'd0), 1, 0, 0);
        do_instr(mk(1, 0, RES_ALU, 1, F3_B, 32'h101, 32'h0000005A, 5'd0), 0, 0, 0);
        stall_cnt = 0;
        do_instr(mk(1, 1, RES_LOAD, 0, F3_W, 32'h104, 0, 5'd6), 2, 3, 32'hCAFEF00D);
        chk("lw_stall_cycles", 32'(stall_cnt), 32'd5);
        stall_cnt = 0;
        do_instr(mk(1, 1, RES_LOAD, 0, F3_W, 32'h101, 0, 5'd7), 0, 1, 0);
        chk("lw_misaligned_stalls", 32'(stall_cnt), 32'd0);
        do_instr(mk(1, 1, RES_ALU, 0, F3_W, 32'h12345678, 0, 5'd8), 0, 0, 0);
        do_instr(mk(1, 1, RES_PC4, 0, F3_B, 32'h00000040, 0, 5'd9), 0, 0, 0);
        do_instr(mk(1, 1, RES_LOAD, 0, 3'b011, 32'h200, 0, 5'd10), 0, 1, 0);
        do_instr(mk(1, 0, RES_ALU, 1, F3_BU, 32'h200, 32'h1, 5'd0), 0, 0, 0);

        // randomized traffic
        for (int k = 0; k < 250; k++) begin
            kind = $urandom_range(0, 9);
            ri.valid = 1'($urandom_range(0, 9) != 0);
            ri.regwrite = 1'($urandom_range(0, 1));
            ri.alu = $urandom; ri.wd = $urandom; ri.pc4 = $urandom; ri.rd = 5'($urandom);
            if ($urandom_range(0, 1) == 1) ri.alu[1:0] = 2'b00;
            if (kind < 3) begin
                ri.mw = 1'b0; ri.rs = ($urandom_range(0, 1) == 1) ? RES_PC4 : RES_ALU;
                ri.f3 = 3'($urandom);
            end else if (kind < 7) begin
                ri.mw = 1'b0; ri.rs = RES_LOAD;
                ri.f3 = ld_f3[$urandom_range(0, 4)];
            end else begin
                ri.mw = 1'b1; ri.rs = RES_ALU;
                ri.f3 = 3'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 7) == 0) ri.f3 = 3'($urandom);
            do_instr(ri, $urandom_range(0, 3), $urandom_range(1, 5), $urandom);
        end
        do_instr(mk(1, 0, RES_ALU, 0, F3_B, 32'h0, 0, 5'd0), 0, 0, 0);
        @(negedge clk); #1;
        chk_en = 1'b0;

        // reset while a load waits for data; the late rvalid must be dropped
        @(posedge clk); #1;
        set_m(mk(1, 1, RES_LOAD, 0, F3_W, 32'h300, 0, 5'd11));
        dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_pre_state", 32'(fsm_state), 32'(WAIT_R));
        chk("rst_mid_pre_stall", 32'(stall_m), 32'h1);
        #2;
        reset_n = 1'b0; valid_m = 1'b0;
        #1;
        chk("rst_mid_state", 32'(fsm_state), 32'(IDLE));
        chk("rst_mid_stall", 32'(stall_m), 32'h0);
        chk("rst_mid_req", 32'(dmem_req), 32'h0);
        chk("rst_mid_regwrite", 32'(regwrite_w), 32'h0);
        chk("rst_mid_rd", 32'(rd_w), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #2;
        chk("late_rvalid_stall", 32'(stall_m), 32'h0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        chk("late_rvalid_regwrite", 32'(regwrite_w), 32'h0);
        chk("late_rvalid_readdata", readdata_w, 32'h0);
        chk("late_rvalid_state", 32'(fsm_state), 32'(IDLE));

        // load whose data never arrives
        chk_en = 1'b1;
        stall_cnt = 0;
        do_instr(mk(1, 1, RES_LOAD, 0, F3_W, 32'h400, 0, 5'd12), 0, -1, 0);
        chk("timeout_stall_cycles", 32'(stall_cnt), 32'd256);
        do_instr(mk(1, 1, RES_ALU, 0, F3_B, 32'h44, 0, 5'd13), 0, 0, 0);
        @(negedge clk); #1;
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
